// File: rtl/seq_pkg.sv
// Shared types for the instruction sequencer: FSM states and opcode encodings.
package seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   typedef logic [2:0] opcode_t;

   localparam opcode_t OP_LOAD  = 3'b110;
   localparam opcode_t OP_STORE = 3'b111;

endpackage

// File: rtl/seq_wait_timer.sv
// Wait-cycle counter for memory handshakes; done flags the last permitted wait cycle.
module seq_wait_timer #(
   parameter int TIMEOUT_CYC = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic done
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [TW-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear)
         count <= '0;
      else if (enable)
         count <= count + TW'(1);
   end

   // Count holds the waits already spent, so this cycle is wait number TIMEOUT_CYC.
   assign done = enable && (count == TW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer driving the 16-bit lab datapath
// through req/ack handshakes to instruction and data memory.
module instr_sequencer
   import seq_pkg::*;
#(
   parameter int          PC_W        = 8,
   parameter logic [15:0] HALT_INSTR  = 16'h0000,
   parameter int          TIMEOUT_CYC = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   output logic [PC_W-1:0] imem_addr,
   output logic            imem_req,
   input  logic            imem_ack,
   input  logic [15:0]     imem_rdata,
   output logic [15:0]     instr,
   output logic [2:0]      alu_cntr,
   output logic            alu_or_m,
   output logic            dmem_req,
   output logic            dmem_we,
   input  logic            dmem_ack,
   output logic            rf_we,
   output logic            busy,
   output logic            halted,
   output logic            err
);

   state_t          state;
   logic [PC_W-1:0] pc;
   logic [15:0]     ir;
   opcode_t         op;
   logic            is_mem;
   logic            waiting;
   logic            timed_out;

   assign op        = ir[15:13];
   assign is_mem    = (op == OP_LOAD) || (op == OP_STORE);
   assign imem_addr = pc;
   assign instr     = ir;
   assign alu_cntr  = op;
   assign alu_or_m  = (op == OP_LOAD);

   // Any cycle in a handshake state without its ack is a wait; anything else restarts the count.
   assign waiting = ((state == S_FETCH) && !imem_ack) || ((state == S_MEM) && !dmem_ack);

   seq_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (!waiting),
      .enable (waiting),
      .done   (timed_out)
   );

   // Outputs are registered together with the state so each one is exact to its state's cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         pc       <= '0;
         ir       <= '0;
         err      <= 1'b0;
         imem_req <= 1'b0;
         dmem_req <= 1'b0;
         dmem_we  <= 1'b0;
         rf_we    <= 1'b0;
         busy     <= 1'b0;
         halted   <= 1'b0;
      end else begin
         rf_we <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_FETCH;
                  imem_req <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            S_FETCH: begin
               if (imem_ack) begin
                  ir       <= imem_rdata;
                  imem_req <= 1'b0;
                  state    <= S_DECODE;
               end else if (timed_out) begin
                  err      <= 1'b1;
                  imem_req <= 1'b0;
                  busy     <= 1'b0;
                  halted   <= 1'b1;
                  state    <= S_HALT;
               end
            end
            S_DECODE: begin
               if (ir == HALT_INSTR) begin
                  busy   <= 1'b0;
                  halted <= 1'b1;
                  state  <= S_HALT;
               end else begin
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (is_mem) begin
                  dmem_req <= 1'b1;
                  dmem_we  <= (op == OP_STORE);
                  state    <= S_MEM;
               end else begin
                  rf_we <= 1'b1;
                  state <= S_WB;
               end
            end
            S_MEM: begin
               if (dmem_ack) begin
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  if (op == OP_STORE) begin
                     pc       <= pc + PC_W'(1);
                     imem_req <= 1'b1;
                     state    <= S_FETCH;
                  end else begin
                     rf_we <= 1'b1;
                     state <= S_WB;
                  end
               end else if (timed_out) begin
                  err      <= 1'b1;
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  busy     <= 1'b0;
                  halted   <= 1'b1;
                  state    <= S_HALT;
               end
            end
            S_WB: begin
               pc       <= pc + PC_W'(1);
               imem_req <= 1'b1;
               state    <= S_FETCH;
            end
            S_HALT: begin
               state <= S_HALT;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: directed programs push expected handshake
// events; a negedge monitor pops and compares every event the DUTs present.
module tb_instr_sequencer;

   typedef struct packed {
      logic        u;
      logic [1:0]  kind;
      logic [7:0]  addr;
      logic [2:0]  cntr;
      logic        orm;
      logic        flag;
      logic [15:0] t;
   } ev_t;

   localparam logic [1:0] EV_FETCH = 2'd0;
   localparam logic [1:0] EV_WB    = 2'd1;
   localparam logic [1:0] EV_DMEM  = 2'd2;
   localparam logic [1:0] EV_HALT  = 2'd3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  imem_addr;
   logic        imem_req, imem_ack;
   logic [15:0] imem_rdata, instr;
   logic [2:0]  alu_cntr;
   logic        alu_or_m, dmem_req, dmem_we, dmem_ack, rf_we, busy, halted, err;

   logic        reset4 = 1'b1;
   logic        start4 = 1'b0;
   logic [3:0]  imem_addr4;
   logic        imem_req4, imem_ack4;
   logic [15:0] imem_rdata4, instr4;
   logic [2:0]  alu_cntr4;
   logic        alu_or_m4, dmem_req4, dmem_we4, rf_we4, busy4, halted4, err4;

   logic [15:0] imem [256];
   int          imemDelay = 0;
   int          dmemDelay = 0;
   logic        imemEn = 1'b1;
   int          iWait = 0;
   int          dWait = 0;

   int          cyc = 0;
   int          t0 = 0;
   int          nChecks = 0;
   int          nFail = 0;
   int          nRfwe = 0;
   int          nDreq = 0;
   int          nIreq = 0;
   int          nRfwe4 = 0;
   logic        haltedPrev = 1'b0;
   ev_t         expQ [$];

   always #5 clk = ~clk;

   instr_sequencer #(.PC_W(8), .HALT_INSTR(16'h0000), .TIMEOUT_CYC(16)) dut (
      .clk(clk), .reset(reset), .start(start),
      .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr(instr), .alu_cntr(alu_cntr), .alu_or_m(alu_or_m),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
      .rf_we(rf_we), .busy(busy), .halted(halted), .err(err)
   );

   instr_sequencer #(.PC_W(4), .HALT_INSTR(16'h0000), .TIMEOUT_CYC(16)) dut4 (
      .clk(clk), .reset(reset4), .start(start4),
      .imem_addr(imem_addr4), .imem_req(imem_req4), .imem_ack(imem_ack4), .imem_rdata(imem_rdata4),
      .instr(instr4), .alu_cntr(alu_cntr4), .alu_or_m(alu_or_m4),
      .dmem_req(dmem_req4), .dmem_we(dmem_we4), .dmem_ack(1'b0),
      .rf_we(rf_we4), .busy(busy4), .halted(halted4), .err(err4)
   );

   // Memory models: ack after a programmable number of wait cycles.
   assign imem_rdata  = imem[imem_addr];
   assign imem_ack    = imem_req && imemEn && (iWait == imemDelay);
   assign dmem_ack    = dmem_req && (dWait == dmemDelay);
   assign imem_rdata4 = {12'h200, imem_addr4};
   assign imem_ack4   = imem_req4;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      iWait <= (imem_req && !imem_ack) ? iWait + 1 : 0;
      dWait <= (dmem_req && !dmem_ack) ? dWait + 1 : 0;
   end

   function automatic ev_t mkEv(input logic u, input logic [1:0] kind, input logic [7:0] addr,
                                input logic [2:0] cntr, input logic orm, input logic flag, input int t);
      ev_t e;
      e.u = u; e.kind = kind; e.addr = addr; e.cntr = cntr; e.orm = orm; e.flag = flag; e.t = 16'(t);
      return e;
   endfunction

   function automatic string fmtEv(input ev_t e);
      return $sformatf("u=%0d kind=%0d addr=%0h cntr=%0d orm=%0d flag=%0d t=%0d",
                       e.u, e.kind, e.addr, e.cntr, e.orm, e.flag, e.t);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
      nChecks++;
      if (got !== want) begin
         nFail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
      end
   endtask

   task automatic checkEvent(input ev_t got);
      ev_t want;
      nChecks++;
      if (expQ.size() == 0) begin
         nFail++;
         $display("[TB] FAIL event_unexpected: got %s, expected none", fmtEv(got));
      end else begin
         want = expQ.pop_front();
         if (got !== want) begin
            nFail++;
            $display("[TB] FAIL event: got %s, expected %s", fmtEv(got), fmtEv(want));
         end
      end
   endtask

   // Monitor: turns handshake completions, write strobes and halt entry into scoreboard events.
   always @(negedge clk) begin
      int rel;
      rel = cyc - t0;
      if (!reset) begin
         if (imem_req && imem_ack) checkEvent(mkEv(1'b0, EV_FETCH, imem_addr, 3'd0, 1'b0, 1'b0, rel));
         if (rf_we) checkEvent(mkEv(1'b0, EV_WB, imem_addr, alu_cntr, alu_or_m, 1'b0, rel));
         if (dmem_req && dmem_ack) checkEvent(mkEv(1'b0, EV_DMEM, imem_addr, alu_cntr, alu_or_m, dmem_we, rel));
         if (halted && !haltedPrev) checkEvent(mkEv(1'b0, EV_HALT, imem_addr, 3'd0, 1'b0, err, rel));
         if (rf_we) nRfwe++;
         if (dmem_req) nDreq++;
         if (imem_req) nIreq++;
      end
      if (!reset4) begin
         if (imem_req4 && imem_ack4) checkEvent(mkEv(1'b1, EV_FETCH, {4'h0, imem_addr4}, 3'd0, 1'b0, 1'b0, rel));
         if (rf_we4) begin
            checkEvent(mkEv(1'b1, EV_WB, {4'h0, imem_addr4}, alu_cntr4, alu_or_m4, 1'b0, rel));
            nRfwe4++;
         end
      end
      haltedPrev = halted;
   end

   task automatic applyStimulus(input logic [15:0] w0, input logic [15:0] w1,
                                input int idel, input int ddel, input logic ien);
      @(negedge clk);
      reset = 1'b1;
      start = 1'b0;
      for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
      imem[0] = w0;
      imem[1] = w1;
      imemDelay = idel;
      dmemDelay = ddel;
      imemEn = ien;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      start = 1'b1;
      t0 = cyc;
   endtask

   task automatic waitHalt(input int budget);
      for (int k = 0; k < budget && !halted; k++) @(negedge clk);
      checkOutput("halt_reached", 32'(halted), 32'd1);
      @(negedge clk);
      checkOutput("queue_drained", expQ.size(), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int baseR, baseD, baseI;
      for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
      repeat (2) @(negedge clk);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_halted", 32'(halted), 32'd0);
      checkOutput("reset_err", 32'(err), 32'd0);
      checkOutput("reset_reqs", {28'd0, imem_req, dmem_req, dmem_we, rf_we}, 32'd0);
      checkOutput("reset_pc_ir", {8'd0, imem_addr, instr}, 32'd0);
      checkOutput("reset_alu", {28'd0, alu_cntr, alu_or_m}, 32'd0);

      $display("[TB] ALU op then halt");
      applyStimulus(16'hA100, 16'h0000, 0, 0, 1'b1);
      baseR = nRfwe;
      expQ.push_back(mkEv(1'b0, EV_FETCH, 8'd0, 3'd0, 1'b0, 1'b0, 1));
      expQ.push_back(mkEv(1'b0, EV_WB,    8'd0, 3'd5, 1'b0, 1'b0, 4));
      expQ.push_back(mkEv(1'b0, EV_FETCH, 8'd1, 3'd0, 1'b0, 1'b0, 5));
      expQ.push_back(mkEv(1'b0, EV_HALT,  8'd1, 3'd0, 1'b0, 1'b0, 7));
      waitHalt(40);
      checkOutput("alu_rfwe_count", nRfwe - baseR, 32'd1);
      checkOutput("alu_busy_after_halt", 32'(busy), 32'd0);
      checkOutput("alu_pc_after", 32'(imem_addr), 32'd1);

      $display("[TB] LOAD with three data wait cycles");
      applyStimulus(16'hD1FE, 16'h0000, 0, 3, 1'b1);
      baseR = nRfwe;
      baseD = nDreq;
      expQ.push_back(mkEv(1'b0, EV_FETCH, 8'd0, 3'd0, 1'b0, 1'b0, 1));
      expQ.push_back(mkEv(1'b0, EV_DMEM,  8'd0, 3'd6, 1'b1, 1'b0, 7));
      expQ.push_back(mkEv(1'b0, EV_WB,    8'd0, 3'd6, 1'b1, 1'b0, 8));
      expQ.push_back(mkEv(1'b0, EV_FETCH, 8'd1, 3'd0, 1'b0, 1'b0, 9));
      expQ.push_back(mkEv(1'b0, EV_HALT,  8'd1, 3'd0, 1'b0, 1'b0, 11));
      waitHalt(40);
      checkOutput("load_dreq_cycles", nDreq - baseD, 32'd4);
      checkOutput("load_rfwe_count", nRfwe - baseR, 32'd1);

      $display("[TB] STORE with immediate ack");
      applyStimulus(16'hF900, 16'h0000, 0, 0, 1'b1);
      baseR = nRfwe;
      expQ.push_back(mkEv(1'b0, EV_FETCH, 8'd0, 3'd0, 1'b0, 1'b0, 1));
      expQ.push_back(mkEv(1'b0, EV_DMEM,  8'd0, 3'd7, 1'b0, 1'b1, 4));
      expQ.push_back(mkEv(1'b0, EV_FETCH, 8'd1, 3'd0, 1'b0, 1'b0, 5));
      expQ.push_back(mkEv(1'b0, EV_HALT,  8'd1, 3'd0, 1'b0, 1'b0, 7));
      waitHalt(40);
      checkOutput("store_rfwe_count", nRfwe - baseR, 32'd0);

      $display("[TB] fetch timeout");
      applyStimulus(16'hA100, 16'h0000, 0, 0, 1'b0);
      baseI = nIreq;
      expQ.push_back(mkEv(1'b0, EV_HALT, 8'd0, 3'd0, 1'b0, 1'b1, 17));
      waitHalt(60);
      checkOutput("timeout_ireq_cycles", nIreq - baseI, 32'd16);
      repeat (3) @(negedge clk);
      checkOutput("timeout_err", 32'(err), 32'd1);
      checkOutput("timeout_req_dropped", 32'(imem_req), 32'd0);
      checkOutput("timeout_start_ignored", {30'd0, halted, busy}, 32'd2);

      $display("[TB] ack on the limit cycle");
      applyStimulus(16'hA100, 16'h0000, 15, 0, 1'b1);
      expQ.push_back(mkEv(1'b0, EV_FETCH, 8'd0, 3'd0, 1'b0, 1'b0, 16));
      expQ.push_back(mkEv(1'b0, EV_WB,    8'd0, 3'd5, 1'b0, 1'b0, 19));
      expQ.push_back(mkEv(1'b0, EV_FETCH, 8'd1, 3'd0, 1'b0, 1'b0, 35));
      expQ.push_back(mkEv(1'b0, EV_HALT,  8'd1, 3'd0, 1'b0, 1'b0, 37));
      waitHalt(80);
      checkOutput("limit_err_clear", 32'(err), 32'd0);

      $display("[TB] reset during data access");
      applyStimulus(16'hA100, 16'hD1FE, 0, 10, 1'b1);
      expQ.push_back(mkEv(1'b0, EV_FETCH, 8'd0, 3'd0, 1'b0, 1'b0, 1));
      expQ.push_back(mkEv(1'b0, EV_WB,    8'd0, 3'd5, 1'b0, 1'b0, 4));
      expQ.push_back(mkEv(1'b0, EV_FETCH, 8'd1, 3'd0, 1'b0, 1'b0, 5));
      for (int k = 0; k < 30 && !dmem_req; k++) @(negedge clk);
      checkOutput("midmem_req_seen", 32'(dmem_req), 32'd1);
      checkOutput("midmem_pc_before", 32'(imem_addr), 32'd1);
      reset = 1'b1;
      start = 1'b0;
      @(negedge clk);
      checkOutput("midmem_dreq_dropped", {30'd0, dmem_req, dmem_we}, 32'd0);
      checkOutput("midmem_idle", {29'd0, busy, halted, imem_req}, 32'd0);
      checkOutput("midmem_pc_err", {23'd0, err, imem_addr}, 32'd0);
      checkOutput("queue_drained", expQ.size(), 32'd0);

      $display("[TB] four-bit PC wrap");
      @(negedge clk);
      reset4 = 1'b0;
      @(negedge clk);
      baseR = nRfwe4;
      for (int i = 0; i < 16; i++) begin
         expQ.push_back(mkEv(1'b1, EV_FETCH, 8'(i), 3'd0, 1'b0, 1'b0, 1 + 4 * i));
         expQ.push_back(mkEv(1'b1, EV_WB,    8'(i), 3'd1, 1'b0, 1'b0, 4 + 4 * i));
      end
      expQ.push_back(mkEv(1'b1, EV_FETCH, 8'd0, 3'd0, 1'b0, 1'b0, 65));
      start4 = 1'b1;
      t0 = cyc;
      for (int k = 0; k < 100 && (cyc - t0) < 66; k++) @(negedge clk);
      reset4 = 1'b1;
      start4 = 1'b0;
      @(negedge clk);
      checkOutput("wrap_rfwe_count", nRfwe4 - baseR, 32'd16);
      checkOutput("queue_drained", expQ.size(), 32'd0);

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
